// File: rtl/mem_addr_sequencer.sv
// mem_addr_sequencer: LC-3 address-generation and memory-access sequencer
// for LD/LDI/LDR/ST/STI/STR/LEA/JSR.
//
// Ports:
//   Clk, Reset        clock; synchronous active-high reset
//   Start, IR         request and instruction (captured on accept in IDLE)
//   Adder             address adder sum (base and offset chosen by the mux controls)
//   Mem_Rdata         memory read data
//   Mem_Ready         memory acknowledge
//   ADR1MUX_Control   0=PC, 1=SR1
//   ADR2MUX_Control   00=0, 01=SEXT6, 10=SEXT9, 11=SEXT11
//   MAR               memory address
//   Mem_En, Mem_WE    memory request and write qualifier
//   Data_Out          load result or effective address
//   Busy              high outside IDLE
//   Done              one-cycle completion pulse
//   Illegal           one-cycle pulse for a rejected opcode (or an access timeout)
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES cycles without Mem_Ready. Opcode decode assumes DATA_W >= 16.
module mem_addr_sequencer #(
  parameter int DATA_W = 16
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DATA_W-1:0] IR,
  input  logic [DATA_W-1:0] Adder,
  input  logic [DATA_W-1:0] Mem_Rdata,
  input  logic              Mem_Ready,
  output logic              ADR1MUX_Control,
  output logic [1:0]        ADR2MUX_Control,
  output logic [DATA_W-1:0] MAR,
  output logic              Mem_En,
  output logic              Mem_WE,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Busy,
  output logic              Done,
  output logic              Illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_MEM1,
    S_IND,
    S_MEM2,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] ind_q;
  logic              illegal_q, illegal_n;
  logic              ir_ld, mar_ld, dout_ld, ind_ld;
  logic              mem_en, mem_we;
  logic              tmo_hit;

  function automatic logic is_legal(input logic [3:0] op, input logic link);
    case (op)
      4'b0010, 4'b0011, 4'b1010, 4'b1011,
      4'b0110, 4'b0111, 4'b1110: return 1'b1;
      4'b0100:                   return link;
      default:                   return 1'b0;
    endcase
  endfunction

  logic [3:0] opc;
  logic op_ld, op_st, op_ldi, op_sti;
  logic op_ldr, op_str, op_lea, op_jsr;

  assign opc    = ir_q[15:12];
  assign op_ld  = (opc == 4'b0010);
  assign op_st  = (opc == 4'b0011);
  assign op_ldi = (opc == 4'b1010);
  assign op_sti = (opc == 4'b1011);
  assign op_ldr = (opc == 4'b0110);
  assign op_str = (opc == 4'b0111);
  assign op_lea = (opc == 4'b1110);
  // JSRR never reaches ir_q, so the opcode alone identifies JSR here.
  assign op_jsr = (opc == 4'b0100);

  // Only the opcode field of the captured instruction matters here.
  logic unused_ir;
  assign unused_ir = ^ir_q[11:0];

  always_comb begin
    ADR1MUX_Control = 1'b0;
    ADR2MUX_Control = 2'b00;
    if (state != S_IDLE) begin
      if (op_ldr || op_str) begin
        ADR1MUX_Control = 1'b1;
        ADR2MUX_Control = 2'b01;
      end else if (op_jsr) begin
        ADR2MUX_Control = 2'b11;
      end else begin
        ADR2MUX_Control = 2'b10;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Mem_En is low between MEM1 and MEM2 (IND), so each access
  // starts from zero.
  always_ff @(posedge Clk) begin
    if (Reset || !mem_en) tmo_cnt <= '0;
    else                  tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  assign tmo_hit = mem_en && !Mem_Ready &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    ir_ld     = 1'b0;
    mar_ld    = 1'b0;
    mar_d     = Adder;
    dout_ld   = 1'b0;
    dout_d    = Mem_Rdata;
    ind_ld    = 1'b0;
    illegal_n = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (Start) begin
          if (is_legal(IR[15:12], IR[11])) begin
            ir_ld   = 1'b1;
            state_n = S_CALC;
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      S_CALC: begin
        mar_ld = 1'b1;
        mar_d  = Adder;
        if (op_lea || op_jsr) begin
          dout_ld = 1'b1;
          dout_d  = Adder;
          state_n = S_DONE;
        end else begin
          state_n = S_MEM1;
        end
      end
      S_MEM1: begin
        mem_en = 1'b1;
        mem_we = op_st || op_str;
        if (Mem_Ready) begin
          if (op_ldi || op_sti) begin
            ind_ld  = 1'b1;
            state_n = S_IND;
          end else begin
            dout_ld = op_ld || op_ldr;
            state_n = S_DONE;
          end
        end else if (tmo_hit) begin
          illegal_n = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_IND: begin
        mar_ld  = 1'b1;
        mar_d   = ind_q;
        state_n = S_MEM2;
      end
      S_MEM2: begin
        mem_en = 1'b1;
        mem_we = op_sti;
        if (Mem_Ready) begin
          dout_ld = op_ldi;
          state_n = S_DONE;
        end else if (tmo_hit) begin
          illegal_n = 1'b1;
          state_n   = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= S_IDLE;
      ir_q      <= '0;
      mar_q     <= '0;
      dout_q    <= '0;
      ind_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_n;
      illegal_q <= illegal_n;
      if (ir_ld)   ir_q   <= IR;
      if (mar_ld)  mar_q  <= mar_d;
      if (dout_ld) dout_q <= dout_d;
      if (ind_ld)  ind_q  <= Mem_Rdata;
    end
  end

  assign MAR      = mar_q;
  assign Data_Out = dout_q;
  assign Mem_En   = mem_en;
  assign Mem_WE   = mem_we;
  assign Busy     = (state != S_IDLE);
  assign Done     = (state == S_DONE);
  assign Illegal  = illegal_q;

endmodule
